sdram_host_ram_responder: RTL and testbench

- Synthesizable responder on the SDRAM controller host interface (wr_*/rd_*/busy/rd_ready), backed by on-chip RAM instead of external SDRAM.
- Drop-in stand-in for sdram_controller, so host-side initiators (sdram_test, future DMA/video masters) can be exercised in simulation and on the board without the PHY.
- Emulates controller timing: init stall, per-access busy windows, read latency, and periodic refresh stalls.

---
 rtl/sdram_host_pkg.sv | 23 ++
 rtl/sdram_host_ram.sv | 31 +++
 rtl/sdram_host_ram_responder.sv | 149 ++++++++++++++
 tb/tb_sdram_host_ram_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_host_pkg.sv
// Shared types and default timing for the SDRAM host-interface responder.
// Timing defaults match sdram_controller so the responder can be swapped in.
package sdram_host_pkg;

  localparam int DATA_W      = 16;
  localparam int HOST_ADDR_W = 32;
  localparam int CNT_W       = 16;

  localparam int DEF_INIT_CYCLES    = 200;
  localparam int DEF_WR_LATENCY     = 2;
  localparam int DEF_RD_LATENCY     = 4;
  localparam int DEF_REFRESH_PERIOD = 780;
  localparam int DEF_REFRESH_CYCLES = 8;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REFRESH
  } state_e;

endpackage

// File: rtl/sdram_host_ram.sv
// Single-port synchronous RAM, write-first, registered read; infers block RAM.
module sdram_host_ram
  import sdram_host_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_host_ram_responder.sv
// Host-side stand-in for sdram_controller: on-chip RAM behind the wr_*/rd_* interface,
// reproducing init stall, access busy windows, read latency and refresh stalls.
module sdram_host_ram_responder
  import sdram_host_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int INIT_CYCLES    = DEF_INIT_CYCLES,
  parameter int WR_LATENCY     = DEF_WR_LATENCY,
  parameter int RD_LATENCY     = DEF_RD_LATENCY,
  parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HOST_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_enable,
  input  logic [HOST_ADDR_W-1:0] rd_addr,
  input  logic                   rd_enable,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_ready,
  output logic                   busy,
  output logic [7:0]             dropped_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   ref_cnt_q, ref_cnt_d;
  logic               ref_pend_q, ref_pend_d;
  logic               busy_q, busy_d;
  logic               rd_ready_q, rd_ready_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic [7:0]         dropped_q, dropped_d;
  logic               ram_en, ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^{wr_addr[HOST_ADDR_W-1:ADDR_W], rd_addr[HOST_ADDR_W-1:ADDR_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      busy_q     <= 1'b1;
      rd_ready_q <= 1'b0;
      rd_data_q  <= '0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      busy_q     <= busy_d;
      rd_ready_q <= rd_ready_d;
      rd_data_q  <= rd_data_d;
      dropped_q  <= dropped_d;
    end
  end

  // cnt_q counts cycles spent in the current non-idle state, starting at 0 on entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_W'(INIT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        cnt_d = '0;
        if (wr_enable)       state_d = ST_WRITE;
        else if (rd_enable)  state_d = ST_READ;
        else if (ref_pend_q) state_d = ST_REFRESH;
      end
      ST_WRITE: begin
        if (cnt_q == CNT_W'(WR_LATENCY - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_READ: begin
        if (cnt_q == CNT_W'(RD_LATENCY - 2)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_REFRESH: begin
        if (cnt_q == CNT_W'(REFRESH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    rd_ready_d = (state_q == ST_READ) && (state_d == ST_IDLE);
    rd_data_d  = rd_ready_d ? ram_rdata : rd_data_q;
    ram_en     = (state_q == ST_IDLE) && (wr_enable || rd_enable);
    ram_we     = (state_q == ST_IDLE) && wr_enable;
    ram_addr   = wr_enable ? wr_addr[ADDR_W-1:0] : rd_addr[ADDR_W-1:0];

    // A same-cycle write+read while idle loses the read; count that as a drop too.
    dropped_d = dropped_q;
    if (((busy_q && (wr_enable || rd_enable)) || (!busy_q && wr_enable && rd_enable))
        && (dropped_q != 8'hFF))
      dropped_d = dropped_q + 8'd1;

    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if ((state_q == ST_IDLE) && (state_d == ST_REFRESH))
      ref_pend_d = 1'b0;
    if ((REFRESH_PERIOD != 0) && (state_q != ST_INIT)) begin
      if (ref_cnt_q == CNT_W'(REFRESH_PERIOD - 1)) begin
        ref_cnt_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_cnt_d = ref_cnt_q + CNT_W'(1);
      end
    end
  end

  sdram_host_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(wr_data),
    .rdata_o(ram_rdata)
  );

  assign busy        = busy_q;
  assign rd_ready    = rd_ready_q;
  assign rd_data     = rd_data_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_sdram_host_ram_responder.sv
// Directed bench for sdram_host_ram_responder: init stall, write/read latency,
// address wrap, refresh stalls, simultaneous requests, mid-read reset, drop saturation.
module tb_sdram_host_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wr_addr, rd_addr;
  logic [15:0] wr_data;
  logic        wr_enable, rd_enable;
  logic [15:0] rd_data;
  logic        rd_ready, busy;
  logic [7:0]  dropped_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sdram_host_ram_responder #(
    .ADDR_W        (12),
    .INIT_CYCLES   (200),
    .WR_LATENCY    (2),
    .RD_LATENCY    (4),
    .REFRESH_PERIOD(50),
    .REFRESH_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_enable  (wr_enable),
    .rd_addr    (rd_addr),
    .rd_enable  (rd_enable),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .dropped_cnt(dropped_cnt)
  );

  typedef struct {
    logic [31:0] wa;
    logic [15:0] wd;
    logic [31:0] ra;
    logic [15:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Cycle T is the cycle in which the request is driven with busy=0.
  task automatic do_write(input logic [31:0] a, input logic [15:0] d);
    wait_idle();
    wr_addr   = a;
    wr_data   = d;
    wr_enable = 1'b1;
    tick();
    wr_enable = 1'b0;
    check($sformatf("wr_%0h_busy_T1", a), {31'd0, busy}, 32'd1);
    tick();
    check($sformatf("wr_%0h_busy_T2", a), {31'd0, busy}, 32'd1);
    tick();
    check($sformatf("wr_%0h_busy_T3", a), {31'd0, busy}, 32'd0);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [15:0] d);
    wait_idle();
    rd_addr   = a;
    rd_enable = 1'b1;
    tick();
    rd_enable = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("rd_%0h_T%0d_busy_rdy", a, i), {30'd0, busy, rd_ready}, 32'b10);
      tick();
    end
    check($sformatf("rd_%0h_T4_busy_rdy", a), {30'd0, busy, rd_ready}, 32'b01);
    d = rd_data;
    tick();
    check($sformatf("rd_%0h_T5_rdy", a), {31'd0, rd_ready}, 32'd0);
  endtask

  // Counts clocks from reset release until busy drops; holds wr_enable for hold_wr edges.
  task automatic init_sequence(input int hold_wr, output int n, output bit saw_ready);
    n = 0;
    saw_ready = 1'b0;
    while (busy !== 1'b0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
      if (n == hold_wr) wr_enable = 1'b0;
      if (rd_ready) saw_ready = 1'b1;
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    int          n;
    bit          saw;
    logic        exp_busy, exp_rdy;
    logic [15:0] got;
    logic [7:0]  d0;

    vecs[0] = '{32'h0000_0000, 16'h5555, 32'h0000_0000, 16'h5555};
    vecs[1] = '{32'h0000_1000, 16'hA5A5, 32'h0000_0000, 16'hA5A5};
    vecs[2] = '{32'h0000_0FFF, 16'h1234, 32'hFFFF_FFFF, 16'h1234};
    vecs[3] = '{32'h0000_2ABC, 16'hBEEF, 32'h0000_0ABC, 16'hBEEF};
    vecs[4] = '{32'h0000_0001, 16'h0F0F, 32'h0000_1001, 16'h0F0F};

    rst_n = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    #50;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);
    check("rst_dropped", {24'd0, dropped_cnt}, 32'd0);

    // First init with one dropped write pulse on the first cycle after release.
    wr_addr = 32'd7; wr_data = 16'hDEAD; wr_enable = 1'b1;
    #50;
    rst_n = 1'b1;
    init_sequence(1, n, saw);
    check("init_busy_cycles", n, 32'd200);
    check("init_dropped", {24'd0, dropped_cnt}, 32'd1);

    // Idle bus from IDLE entry (k=0): refresh windows at 51..58 and 101..108.
    // A read accepted at k=150 (refresh due) completes at 154, then refresh runs 155..162.
    rd_addr = 32'd0;
    for (int k = 1; k <= 163; k++) begin
      tick();
      exp_busy = ((k >= 51) && (k <= 58)) || ((k >= 101) && (k <= 108)) ||
                 ((k >= 151) && (k <= 153)) || ((k >= 155) && (k <= 162));
      exp_rdy  = (k == 154);
      check($sformatf("refresh_k%0d", k), {30'd0, busy, rd_ready}, {30'd0, exp_busy, exp_rdy});
      rd_enable = (k == 150);
    end
    rd_enable = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i].wa, vecs[i].wd);
      do_read(vecs[i].ra, got);
      check($sformatf("vec%0d_data", i), {16'd0, got}, {16'd0, vecs[i].exp});
      if (i == 0) begin
        repeat (10) tick();
        check("rd_data_hold", {16'd0, rd_data}, 32'h5555);
      end
    end

    // Simultaneous write and read: write executes, read dropped.
    d0 = dropped_cnt;
    wait_idle();
    wr_addr = 32'h20; wr_data = 16'h7777; rd_addr = 32'h21;
    wr_enable = 1'b1; rd_enable = 1'b1;
    tick();
    wr_enable = 1'b0; rd_enable = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rd_ready) saw = 1'b1;
      tick();
    end
    check("simul_no_rd_ready", {31'd0, saw}, 32'd0);
    check("simul_dropped", {24'd0, dropped_cnt}, {24'd0, d0 + 8'd1});
    do_read(32'h20, got);
    check("simul_write_data", {16'd0, got}, 32'h7777);

    // Back-to-back writes then reads, each issued on the first busy=0 cycle.
    d0 = dropped_cnt;
    for (int a = 0; a < 16; a++) do_write(32'(a), 16'(a * 3));
    for (int a = 0; a < 16; a++) begin
      do_read(32'(a), got);
      check($sformatf("b2b_data_%0d", a), {16'd0, got}, 32'(a * 3));
    end
    check("b2b_dropped", {24'd0, dropped_cnt}, {24'd0, d0});

    // Reset at T+2 of a read: no rd_ready, async busy, init restarts.
    do_write(32'd7, 16'h1111);
    wait_idle();
    rd_addr = 32'd7; rd_enable = 1'b1;
    tick();
    rd_enable = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    check("midrst_rd_ready", {31'd0, rd_ready}, 32'd0);
    check("midrst_rd_data", {16'd0, rd_data}, 32'd0);
    check("midrst_dropped", {24'd0, dropped_cnt}, 32'd0);
    wr_addr = 32'd7; wr_data = 16'hDEAD; wr_enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    init_sequence(5, n, saw);
    check("reinit_busy_cycles", n, 32'd200);
    check("reinit_no_rd_ready", {31'd0, saw}, 32'd0);
    check("reinit_dropped", {24'd0, dropped_cnt}, 32'd5);
    do_read(32'd7, got);
    check("reinit_ram_unchanged", {16'd0, got}, 32'h1111);

    // Holding a write request continuously drives dropped_cnt into saturation.
    wait_idle();
    wr_addr = 32'h40; wr_data = 16'h0; wr_enable = 1'b1;
    repeat (400) tick();
    wr_enable = 1'b0;
    tick();
    check("dropped_saturate", {24'd0, dropped_cnt}, 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
